// File: rtl/token_run_encoder_pkg.sv
// token_pkg: shared types for the token run-length encoder slice.
// Holds the default run-length width, the tracker state enum and the
// FIFO entry layout {sat, len}.
package token_pkg;

  localparam int LEN_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SAT  = 2'd2
  } state_t;

  // Entry layout at the default width; modules built with another LEN_W
  // declare the same {sat, len} layout locally at their own width.
  typedef struct packed {
    logic                 sat;
    logic [LEN_W_DEF-1:0] len;
  } entry_t;

endpackage

// File: rtl/token_run_encoder_if.sv
// token_run_encoder_if: output handshake bundle of the run encoder.
// master = encoder side (drives valid/len/sat), slave = consumer side.
interface token_run_encoder_if #(
  parameter int LEN_W = token_pkg::LEN_W_DEF
);
  logic             out_valid;
  logic             out_ready;
  logic [LEN_W-1:0] out_len;
  logic             out_sat;

  modport master (output out_valid, output out_len, output out_sat, input out_ready);
  modport slave  (input out_valid, input out_len, input out_sat, output out_ready);
endinterface

// File: rtl/token_run_encoder_fifo.sv
// token_fifo: synchronous FIFO, power-of-two depth, extra pointer wrap bit.
// A push while full is accepted only when a pop happens on the same edge.
module token_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset empties the buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents are don't-care until a pointer covers them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/token_run_encoder.sv
// token_run_encoder: measures runs of '1' on in_bit and queues {sat, len}
// per completed run into token_fifo. drop_err is sticky until rst.
// Optional macro TOKEN_RUN_COUNT_EN builds a 16-bit wrapping counter of
// consumer pops on run_count; otherwise run_count is tied to 0.
module token_run_encoder
  import token_pkg::*;
#(
  parameter int LEN_W      = LEN_W_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_bit,
  token_run_encoder_if.master ob,
  output logic                drop_err,
  output logic [15:0]         run_count
);
  typedef struct packed {
    logic             sat;
    logic [LEN_W-1:0] len;
  } entry_w_t;

  localparam logic [LEN_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic [LEN_W-1:0] cnt;
  entry_w_t         push_d, head;
  logic             push, pop, full, empty;

  // A run ends on the first '0' after RUN/SAT; the entry goes in on that edge.
  assign push   = (state != IDLE) && !in_bit;
  assign pop    = ob.out_valid && ob.out_ready;
  assign push_d = '{sat: (state == SAT), len: cnt};

  token_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(entry_w_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_d),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // Outputs read zero while empty so the unreset storage never leaks out.
  assign ob.out_valid = !empty;
  assign ob.out_len   = empty ? '0 : head.len;
  assign ob.out_sat   = empty ? 1'b0 : head.sat;

  // Run tracker FSM plus sticky drop flag (push on full with no pop).
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      drop_err <= 1'b0;
    end else begin
      if (push && full && !pop) drop_err <= 1'b1;
      case (state)
        IDLE: begin
          if (in_bit) begin
            cnt   <= LEN_W'(1);
            state <= RUN;
          end
        end
        RUN: begin
          if (in_bit) begin
            if (cnt == CNT_MAX) state <= SAT;
            else                cnt   <= cnt + 1'b1;
          end else begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        SAT: begin
          if (!in_bit) begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef TOKEN_RUN_COUNT_EN
  // Count accepted entries; natural 16-bit wrap from 65535 to 0.
  always_ff @(posedge clk) begin
    if (rst)      run_count <= '0;
    else if (pop) run_count <= run_count + 16'd1;
  end
`else
  assign run_count = '0;
`endif

endmodule

// File: doc/token_run_encoder.md
TOKEN_RUN_ENCODER -- requirements
Module: token_run_encoder

Interface
REQ-001 Parameter LEN_W, default 8, run-length field width in bits.
REQ-002 Parameter FIFO_DEPTH, default 4, number of output buffer entries, power of two, minimum 2.
REQ-003 clk  input  1  clock; all logic SHALL sample on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_bit  input  1  serial token stream, one bit per cycle, '1' = token.
REQ-006 out_valid  output  1  head FIFO entry is available.
REQ-007 out_ready  input  1  consumer accepts the head entry.
REQ-008 out_len  output  LEN_W  length of a completed run of '1's.
REQ-009 out_sat  output  1  run reached saturation, so out_len is the maximum value.
REQ-010 drop_err  output  1  sticky flag: a completed run was lost because the FIFO was full.
REQ-011 run_count  output  16  number of entries accepted by the consumer; see Configuration.

Function
REQ-012 Run tracker states SHALL be IDLE, RUN and SAT.
REQ-013 IDLE with in_bit=1 SHALL load cnt=1 and go to RUN; IDLE with in_bit=0 SHALL hold.
REQ-014 RUN with in_bit=1 SHALL increment cnt; when cnt=2^LEN_W-1 and in_bit=1, cnt SHALL hold and the tracker SHALL go to SAT.
REQ-015 SAT with in_bit=1 SHALL hold cnt at 2^LEN_W-1.
REQ-016 RUN or SAT with in_bit=0 SHALL push {sat=(state==SAT), len=cnt} on that same edge and go to IDLE.
REQ-017 A run of 1 to 2^LEN_W-1 ones SHALL report its exact length with out_sat=0; a run of 2^LEN_W or more ones SHALL report 2^LEN_W-1 with out_sat=1.
REQ-018 Latency: the terminating '0' is sampled at edge N; out_valid SHALL be 1 in the cycle after edge N when the FIFO was empty.
REQ-019 out_valid SHALL equal "FIFO not empty"; it SHALL NOT depend combinationally on out_ready.
REQ-020 A pop SHALL occur on an edge where out_valid=1 and out_ready=1; out_len and out_sat SHALL be stable while out_valid=1 and out_ready=0.
REQ-021 Push onto a full FIFO with a simultaneous pop SHALL be accepted with no loss.
REQ-022 Push onto a full FIFO without a pop SHALL drop the entry and set drop_err=1; the FIFO contents SHALL be unchanged.
REQ-023 drop_err SHALL stay at 1 until rst.
REQ-024 Push and pop on an empty FIFO in the same cycle SHALL NOT occur, because out_valid=0; the push SHALL be stored.
REQ-025 Entries SHALL be delivered in run-completion order.

Reset
REQ-026 On rst: tracker SHALL be IDLE, cnt=0, FIFO empty, out_valid=0, out_len=0, out_sat=0, drop_err=0, run_count=0.
REQ-027 rst during RUN or SAT SHALL discard the partial run; no entry SHALL be pushed.
REQ-028 rst SHALL override all other inputs in the same cycle.

Configuration
REQ-029 Macro TOKEN_RUN_COUNT_EN, when defined, SHALL enable run_count: it increments on each pop and wraps from 65535 to 0.
REQ-030 When TOKEN_RUN_COUNT_EN is undefined, run_count SHALL be tied to 0 and no counter logic SHALL be built; all other behaviour SHALL be identical.

Structure
REQ-031 Package token_pkg SHALL hold the LEN_W default, the state enum (IDLE, RUN, SAT) and the FIFO entry struct {sat, len}.
REQ-032 The buffer SHALL be a separate sub-module, token_fifo, with parameterised depth and width and push/pop/full/empty ports.
REQ-033 The tracker FSM and drop_err logic SHALL reside in token_run_encoder.

Verification
REQ-034 in_bit=0110111 then 0, with out_ready=1 -> entries (len 2, sat 0) then (len 3, sat 0); out_valid rises 1 cycle after each terminating '0'.
REQ-035 A run of 255 ones then 0 -> (len 255, sat 0); a run of 300 ones then 0 -> (len 255, sat 1).
REQ-036 out_ready=0 with five runs "10" (depth 4) -> four entries held, fifth dropped, drop_err=1 and stays 1; then out_ready=1 -> exactly four len=1 entries drained, drop_err still 1.
REQ-037 FIFO full plus a terminating '0' coinciding with a pop -> no drop, drop_err=0, order preserved.
REQ-038 rst asserted after 5 ones mid-run -> no entry pushed, all outputs 0; the next run "110" -> (len 2).
REQ-039 With TOKEN_RUN_COUNT_EN defined, 3 pops -> run_count=3; with it undefined, run_count=0 throughout.
